// File: rtl/uart_rx_fifo_if.sv
// SFR-side bundle of the UART receive FIFO: read strobe, error clear,
// head byte, occupancy and sticky status flags.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic                     pop;
    logic                     clr_err;
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic [$clog2(DEPTH):0]   rx_count;
    logic                     overrun;
    logic                     frame_err;

    modport master (
        output pop, clr_err,
        input  rx_data, rx_valid, rx_count, overrun, frame_err
    );

    modport slave (
        input  pop, clr_err,
        output rx_data, rx_valid, rx_count, overrun, frame_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a small show-ahead FIFO,
// with sticky overrun / framing-error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 8
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           uart_rx,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_TICK  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK  = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    rx_state_t       state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic [7:0]      shift_reg, shift_next;
    logic [2:0]      bit_cnt, bit_next;
    logic            sync1, sync2;
    logic            push, frame_set;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            do_push, do_pop, overrun_set;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            timer     <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        shift_next = shift_reg;
        bit_next   = bit_cnt;
        push       = 1'b0;
        frame_set  = 1'b0;
        unique case (state)
            IDLE: begin
                timer_next = '0;
                if (!sync2) state_next = START;
            end
            START: begin
                if (timer == HALF_TICK) begin
                    timer_next = '0;
                    bit_next   = '0;
                    state_next = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_TICK) begin
                    timer_next = '0;
                    shift_next = {sync2, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (timer == FULL_TICK) begin
                    timer_next = '0;
                    if (sync2) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                timer_next = '0;
                if (sync2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign do_pop      = bus.pop && (count != '0);
    assign do_push     = push && ((count != FULL_COUNT) || do_pop);
    assign overrun_set = push && (count == FULL_COUNT) && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.overrun   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            if (overrun_set)      bus.overrun <= 1'b1;
            else if (bus.clr_err) bus.overrun <= 1'b0;
            if (frame_set)        bus.frame_err <= 1'b1;
            else if (bus.clr_err) bus.frame_err <= 1'b0;
        end
    end

    assign bus.rx_count = count;
    assign bus.rx_valid = (count != '0);
    assign bus.rx_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo, checked against a
// queue-based model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    logic uart_rx;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] model_q [$];
    logic       model_overrun   = 1'b0;
    logic       model_frame_err = 1'b0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_data;
        exp_data = (model_q.size() != 0) ? model_q[0] : 8'h00;
        check_output({tag, "_count"},   32'(bus.rx_count),  32'(model_q.size()));
        check_output({tag, "_valid"},   32'(bus.rx_valid),  32'(model_q.size() != 0));
        check_output({tag, "_data"},    32'(bus.rx_data),   32'(exp_data));
        check_output({tag, "_overrun"}, 32'(bus.overrun),   32'(model_overrun));
        check_output({tag, "_ferr"},    32'(bus.frame_err), 32'(model_frame_err));
    endtask

    // The stop bit is sampled on the edge after the frame's last driven cycle.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                  input logic pop_at_end, input string tag);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        check_output({tag, "_pre_count"}, 32'(bus.rx_count), 32'(model_q.size()));
        bus.pop = pop_at_end;
        @(negedge clk);
        bus.pop = 1'b0;
        if (pop_at_end && model_q.size() != 0) void'(model_q.pop_front());
        if (stop_bit) begin
            if (model_q.size() < DEPTH) model_q.push_back(data);
            else                        model_overrun = 1'b1;
        end else begin
            model_frame_err = 1'b1;
        end
        check_model(tag);
    endtask

    task automatic do_pop();
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic do_clr();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        model_overrun   = 1'b0;
        model_frame_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        uart_rx     = 1'b1;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        #1 nrst = 1'b0;
        #1;
        check_model("reset");
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);

        apply_stimulus(8'hA5, 1'b1, 1'b0, "a5");
        check_output("a5_const", 32'(bus.rx_data), 32'h A5);
        do_pop();
        check_model("a5_pop");
        check_output("a5_pop_const", 32'(bus.rx_data), 32'h0);
        do_pop();
        check_model("empty_pop");

        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
        check_model("glitch");

        apply_stimulus(8'h3C, 1'b0, 1'b0, "ferr");
        check_output("ferr_const", 32'(bus.frame_err), 32'h1);
        repeat (20) @(negedge clk);
        check_model("ferr_hold");
        uart_rx = 1'b1;
        repeat (48) @(negedge clk);
        check_model("ferr_nostart");
        apply_stimulus(8'h11, 1'b1, 1'b0, "after_ferr");
        check_output("after_ferr_const", 32'(bus.rx_data), 32'h11);
        do_pop();
        do_clr();
        check_model("ferr_clr");

        for (int b = 1; b <= 5; b++) apply_stimulus(8'(b), 1'b1, 1'b0, "fill");
        check_output("fill_overrun_const", 32'(bus.overrun), 32'h1);
        check_output("fill_count_const", 32'(bus.rx_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_output("pop_seq", 32'(bus.rx_data), 32'(i + 1));
            do_pop();
        end
        do_clr();
        check_model("ovr_clr");

        for (int b = 8'h51; b <= 8'h54; b++) apply_stimulus(8'(b), 1'b1, 1'b0, "fill2");
        apply_stimulus(8'h55, 1'b1, 1'b1, "full_pushpop");
        check_output("full_pushpop_count_const", 32'(bus.rx_count), 32'd4);
        check_output("full_pushpop_ovr_const", 32'(bus.overrun), 32'h0);
        for (int i = 0; i < 3; i++) do_pop();
        check_output("last_out_const", 32'(bus.rx_data), 32'h55);
        do_pop();
        check_model("drain");

        apply_stimulus(8'h21, 1'b1, 1'b0, "q1");
        apply_stimulus(8'h22, 1'b1, 1'b0, "q2");
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = (8'h77 >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        nrst = 1'b0;
        model_q.delete();
        model_overrun   = 1'b0;
        model_frame_err = 1'b0;
        #1;
        check_model("midframe_reset");
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        apply_stimulus(8'h12, 1'b1, 1'b0, "post_reset");
        check_output("post_reset_const", 32'(bus.rx_data), 32'h12);

        for (int n = 0; n < 40; n++) begin
            int unsigned act;
            act = $urandom_range(0, 9);
            if (act <= 5) begin
                logic stop_ok;
                stop_ok = ($urandom_range(0, 7) != 0);
                apply_stimulus(8'($urandom_range(0, 255)), stop_ok,
                               ($urandom_range(0, 3) == 0), "rnd_frame");
                if (!stop_ok) begin
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                    uart_rx = 1'b1;
                    repeat (3) @(negedge clk);
                    check_model("rnd_recover");
                end
            end else if (act <= 7) begin
                do_pop();
                check_model("rnd_pop");
            end else if (act == 8) begin
                do_clr();
                check_model("rnd_clr");
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                check_model("rnd_idle");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, giving clk cycles per UART bit (27 MHz / 115200).
REQ-002 SHALL have parameter DEPTH, default 8, giving the FIFO entry count (power of two, 2..64).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port nrst, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port uart_rx, input, 1, the asynchronous serial line (idle high, 8N1, LSB first).
REQ-006 SHALL have port pop, input, 1, the SFR read strobe; one entry is consumed per clk cycle it is high.
REQ-007 SHALL have port clr_err, input, 1, which clears the sticky error flags.
REQ-008 SHALL have port rx_data, output, 8, the FIFO head byte; 8'h00 when empty.
REQ-009 SHALL have port rx_valid, output, 1, high when the FIFO is not empty.
REQ-010 SHALL have port rx_count, output, $clog2(DEPTH)+1, the current FIFO occupancy.
REQ-011 SHALL have port overrun, output, 1, sticky flag: a received byte was dropped because the FIFO was full.
REQ-012 SHALL have port frame_err, output, 1, sticky flag: a stop bit was sampled low.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer (both flops reset to 1) and use only the synchronized value.
REQ-014 SHALL implement receiver states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: on synced line = 0, SHALL go to START and clear the bit timer.
REQ-016 START: at timer = CLKS_PER_BIT/2-1, SHALL sample the line; 0 -> DATA with timer cleared; 1 -> IDLE (glitch, no flag).
REQ-017 DATA: each time the timer reaches CLKS_PER_BIT-1, SHALL sample one bit into the shift register LSB first and clear the timer; after 8 bits SHALL go to STOP.
REQ-018 STOP: at timer = CLKS_PER_BIT-1, SHALL sample the line; 1 -> push byte, go to IDLE; 0 -> discard byte, set frame_err, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL stay until synced line = 1, then go to IDLE; no start-bit detection occurs in this state.
REQ-020 A pushed byte SHALL appear at rx_data/rx_valid/rx_count in the cycle after the stop-bit sample edge.
REQ-021 rx_data SHALL always reflect the current head entry with no extra read latency; pop SHALL advance the head at the next edge.
REQ-022 A pop when empty SHALL be ignored; rx_count SHALL never underflow.
REQ-023 A push when full without a simultaneous pop SHALL drop the byte, set overrun, and leave FIFO contents unchanged.
REQ-024 A simultaneous push and pop SHALL leave rx_count unchanged, including when full (no overrun) and when empty (the pop is ignored; count becomes 1).
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 clr_err SHALL clear overrun and frame_err at the next edge; a set event in the same cycle SHALL take priority (the flag stays 1).

Reset
REQ-027 While nrst = 0, SHALL force state IDLE, timer = 0, pointers = 0, rx_count = 0, rx_valid = 0, rx_data = 8'h00, overrun = 0, frame_err = 0, and synchronizer = 1, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release the receiver SHALL wait for a new falling edge.

Verification (CLKS_PER_BIT = 4, DEPTH = 4)
REQ-029 Send 0xA5 with a valid stop bit -> rx_valid = 1, rx_data = 0xA5, rx_count = 1 one cycle after the stop sample; pulse pop -> rx_valid = 0, rx_data = 0x00.
REQ-030 Low glitch of 1 clk on an idle line -> START then IDLE; rx_count = 0 and frame_err = 0.
REQ-031 Send 0x3C with stop bit = 0, line held low for 20 clks -> frame_err = 1, rx_count = 0, no start detected until the line goes high; then 0x11 is received correctly.
REQ-032 Send 0x01..0x05 with no pops -> rx_count = 4, overrun = 1, pops return 0x01, 0x02, 0x03, 0x04; pulse clr_err -> overrun = 0.
REQ-033 FIFO full and pop in the same cycle as the push of 0x55 -> rx_count stays 4, overrun = 0, 0x55 is last out.
REQ-034 Assert nrst during DATA of 0x77 with 2 bytes queued -> all outputs return to reset values immediately; next frame 0x12 -> rx_data = 0x12, rx_count = 1.
